// File: rtl/tcb_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tcb_arb_if                                             |
// | Description : TCB request/response bundle between a manager and a    |
// |               subordinate.                                           |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface tcb_arb_if #(
  parameter int AW = 15,
  parameter int DW = 32,
  parameter int BW = DW/8
);
  logic          vld;
  logic          wen;
  logic [AW-1:0] adr;
  logic [BW-1:0] ben;
  logic [DW-1:0] wdt;
  logic [DW-1:0] rdt;
  logic          rdy;

  modport master (output vld, wen, adr, ben, wdt, input  rdt, rdy);
  modport slave  (input  vld, wen, adr, ben, wdt, output rdt, rdy);
endinterface
`default_nettype wire

// File: rtl/tcb_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tcb_arb                                                |
// | Description : Two-manager to one-subordinate TCB round-robin arbiter |
// |               with stall locking and read-data return routing.       |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tcb_arb #(
  parameter int AW  = 15,
  parameter int DW  = 32,
  parameter int BW  = DW/8,
  parameter int RLY = 1
) (
  input  logic      clk,
  input  logic      rst,
  tcb_arb_if.slave  s0,
  tcb_arb_if.slave  s1,
  tcb_arb_if.master m
);

  logic          r_pri;
  logic          r_lck;
  logic          r_gnt_q;
  logic          w_gnt;
  logic          w_vld;
  logic          w_hs;
  logic          w_sel;
  logic          w_wen;
  logic [AW-1:0] w_adr;
  logic [BW-1:0] w_ben;
  logic [DW-1:0] w_wdt;

  // With a single requester the grant follows it; the pointer only breaks ties.
  always_comb begin
    w_gnt = r_pri;
    if (r_lck) begin
      w_gnt = r_gnt_q;
    end else if (s0.vld ^ s1.vld) begin
      w_gnt = s1.vld;
    end
  end

  assign w_vld = w_gnt ? s1.vld : s0.vld;
  assign w_wen = w_gnt ? s1.wen : s0.wen;
  assign w_adr = w_gnt ? s1.adr : s0.adr;
  assign w_ben = w_gnt ? s1.ben : s0.ben;
  assign w_wdt = w_gnt ? s1.wdt : s0.wdt;

  assign m.vld = rst & w_vld;
  assign m.wen = w_wen;
  assign m.adr = w_adr;
  assign m.ben = w_ben;
  assign m.wdt = w_wdt;

  assign s0.rdy = rst & ~w_gnt & m.rdy;
  assign s1.rdy = rst &  w_gnt & m.rdy;

  assign w_hs = m.vld & m.rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pri   <= 1'b0;
      r_lck   <= 1'b0;
      r_gnt_q <= 1'b0;
    end else if (w_hs) begin
      r_pri   <= ~w_gnt;
      r_lck   <= 1'b0;
    end else if (m.vld) begin
      r_lck   <= 1'b1;
      r_gnt_q <= w_gnt;
    end
  end

  // Read data follows the transfer owner: remembered for one cycle when
  // the subordinate has a registered read, or the live grant otherwise.
  generate
    if (RLY == 0) begin : g_rly0
      assign w_sel = w_gnt;
    end else begin : g_rly1
      logic r_rsp;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_rsp <= 1'b0;
        end else if (w_hs) begin
          r_rsp <= w_gnt;
        end
      end
      assign w_sel = r_rsp;
    end
  endgenerate

  assign s0.rdt = (rst & ~w_sel) ? m.rdt : '0;
  assign s1.rdt = (rst &  w_sel) ? m.rdt : '0;

endmodule
`default_nettype wire
